reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised successor to the single-port processor register file: a 2-read/1-write register file with an integrated busy-bit scoreboard for the pipelined IDIOT core. Decode reads two operands per cycle and claims a destination register; writeback writes the result and releases the claim. Same-cycle write-to-read forwarding is built in. A fixed debug tap register is exported for the bench.

## Interface
- WIDTH, 16: data word width in bits; matches `WORD at the default.
- DEPTH, 64: number of registers.
- SEL_W, 6: select width; requires DEPTH <= 2**SEL_W.
- TEST_REG, 0: index of the register driven on testreg.
- clk  in  1  the single clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset; sampled on clk rising edge.
- rd_a_sel, rd_b_sel  in  SEL_W  read-port selects.
- rd_a_data, rd_b_data  out  WIDTH  read data, combinational, forwarded.
- rd_a_busy, rd_b_busy  out  1  selected register has an outstanding claim, forwarded.
- wr_en  in  1  writeback strobe.
- wr_sel  in  SEL_W  writeback register.
- wr_data  in  WIDTH  writeback data.
- claim_en  in  1  decode claims claim_sel as a pending destination.
- claim_sel  in  SEL_W  register being claimed.
- claim_conflict  out  1  sticky: a claim hit an already-busy register.
- busy_count  out  $clog2(DEPTH+1)  number of busy registers.
- testreg  out  WIDTH  registered contents of register TEST_REG, without forwarding.

## Operation
- Storage: DEPTH x WIDTH registers plus a DEPTH-bit busy vector.
- Write: when wr_en=1, regs[wr_sel] <= wr_data and busy[wr_sel] <= 0 at the edge.
- Claim: when claim_en=1, busy[claim_sel] <= 1 at the edge.
- Claim to a register already busy (after same-cycle release is applied) sets claim_conflict <= 1. claim_conflict holds until clear.
- Simultaneous claim and write to the same register:
  - data is written;
  - busy ends at 1 (the claim wins);
  - no conflict is flagged.
- Read forwarding: if wr_en=1 and wr_sel equals rd_x_sel, then rd_x_data = wr_data and rd_x_busy = 0. Otherwise the port returns stored state.
- A same-cycle claim is not visible on rd_x_busy until the next cycle.
- Select values >= DEPTH: reads return 0 with busy 0; writes and claims are ignored.
- busy_count equals the population count of the busy vector, kept as a counter:
  - +1 on a claim of a non-busy register;
  - -1 on a release of a busy register;
  - net 0 when both happen, or on a same-register claim+write.
- clear=1 has priority over wr_en and claim_en. It sets all registers, busy bits, busy_count and claim_conflict to 0.

## Timing
- Reset values: rd data 0, busy outputs 0, claim_conflict 0, busy_count 0, testreg 0.
- Read latency: 0 cycles (combinational from selects and the write port).
- Write latency: 1 cycle. Stored data is visible without forwarding on the cycle after the edge.
- Claim latency: 1 cycle to rd_x_busy and busy_count.
- Clear asserted mid-stream: state is zero after that edge. Operations presented in the same cycle are discarded.
- No handshake: every strobe is a single-cycle request and is always accepted.

## Structure
- signals.v gains `REGSEL (6-bit select) and default-width defines.
- The existing `WORD, `regModeIn and `regModeOut defines stay unchanged.
- Sub-module reg_scoreboard holds:
  - the busy vector;
  - busy_count;
  - claim_conflict;
  - the claim/release priority logic.
- The top level holds data storage, forwarding muxes and the testreg tap.

## Test plan
- Reset/readback: assert clear for one edge, then deassert.
  - Expect all rd data, busy_count and testreg to be 0.
  - Write 16'h000f to reg 0; expect testreg = 16'h000f on the next cycle.
- Dual read + forwarding: regs 3 = 16'h1234 and 5 = 16'hbeef.
  - rd_a_sel=3, rd_b_sel=5, with wr_en writing 16'h5555 to 5 in the same cycle.
  - Expect rd_a=16'h1234 and rd_b=16'h5555 in that cycle.
- Claim/release: claim 7.
  - Next cycle: rd_a_busy=1 on sel 7 and busy_count=1.
  - Write 7 with 16'h00aa: rd_a_busy=0 in the write cycle (forwarded) and busy_count=0 after the edge.
- Simultaneous claim+write on reg 9 (already busy):
  - busy stays 1, data updated, busy_count unchanged, claim_conflict stays 0.
  - Claiming busy reg 9 again with no write sets claim_conflict=1 and holds it.
- Saturation + mid-stream clear: claim regs 0..63 over 64 cycles; expect busy_count=64.
  - Assert clear together with claim_en and wr_en.
  - Expect busy_count=0, claim_conflict=0, all registers 0 after the edge.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_sb_pkg
//
// Shared definitions for the 2-read/1-write register file with busy-bit
// scoreboard used by the pipelined IDIOT core.
//
// Contents:
//   DEF_*       default parameter values (16-bit words, 64 registers,
//               6-bit selects, debug tap on register 0)
//   cnt_op_e    what the busy counter does on a given edge
//   count_op()  maps "new claim" / "busy release" events to a cnt_op_e
// ---------------------------------------------------------------------------
package reg_file_sb_pkg;

   localparam int DEF_WIDTH    = 16;  // data word width
   localparam int DEF_DEPTH    = 64;  // number of registers
   localparam int DEF_SEL_W    = 6;   // register select width
   localparam int DEF_TEST_REG = 0;   // register exported on the debug tap

   // Busy counter action for one clock edge.
   typedef enum logic [1:0] {
      CNT_HOLD = 2'b00,
      CNT_INC  = 2'b01,
      CNT_DEC  = 2'b10
   } cnt_op_e;

   // A claim that makes a non-busy register busy adds one; a write that
   // releases a busy register removes one. When both happen on the same
   // edge the population count is unchanged.
   function automatic cnt_op_e count_op(input logic claim_new,
                                        input logic release_busy);
      cnt_op_e op;
      case ({claim_new, release_busy})
         2'b10:   op = CNT_INC;
         2'b01:   op = CNT_DEC;
         default: op = CNT_HOLD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_file_sb_scoreboard
//
// Busy-bit scoreboard for reg_file_sb. Holds one busy bit per register,
// a running count of busy registers and a sticky claim-conflict flag.
//
// Ports:
//   i_clk              rising-edge clock
//   i_clear            synchronous active-high clear, wins over everything
//   i_wr_en/i_wr_sel   writeback strobe and register; releases the claim
//   i_claim_en/_sel    decode claim strobe and register; sets the busy bit
//   o_busy             registered busy vector (no forwarding applied here)
//   o_busy_count       population count of o_busy, kept as a counter
//   o_claim_conflict   sticky: a claim hit a register that was still busy
//
// Strobes carry no handshake: each is a single-cycle request that is always
// accepted on the edge it is presented.
//
// Selects outside 0..DEPTH-1 decode to no register, so they are ignored.
// DEPTH must not exceed 2**SEL_W.
// ---------------------------------------------------------------------------
module reg_file_sb_scoreboard
   import reg_file_sb_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int SEL_W = DEF_SEL_W,
   parameter int CNT_W = $clog2(DEF_DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_clear,
   input  logic             i_wr_en,
   input  logic [SEL_W-1:0] i_wr_sel,
   input  logic             i_claim_en,
   input  logic [SEL_W-1:0] i_claim_sel,
   output logic [DEPTH-1:0] o_busy,
   output logic [CNT_W-1:0] o_busy_count,
   output logic             o_claim_conflict
);

   logic [DEPTH-1:0] r_busy;
   logic [CNT_W-1:0] r_busy_count;
   logic             r_claim_conflict;

   logic [DEPTH-1:0] w_wr_hit;
   logic [DEPTH-1:0] w_claim_hit;
   logic [DEPTH-1:0] w_busy_rel;
   logic             w_claim_new;
   logic             w_claim_on_busy;
   logic             w_release;
   cnt_op_e          w_cnt_op;

   // One-hot decode of both strobes. An out-of-range select matches no
   // entry, which is how such writes and claims are dropped.
   always_comb begin
      w_wr_hit    = '0;
      w_claim_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_wr_hit[i]    = i_wr_en    && (i_wr_sel    == SEL_W'(i));
         w_claim_hit[i] = i_claim_en && (i_claim_sel == SEL_W'(i));
      end
   end

   // The release is applied before the claim is judged, so a claim and a
   // write to the same busy register is a clean hand-over, not a conflict.
   assign w_busy_rel      = r_busy & ~w_wr_hit;
   assign w_claim_new     = |(w_claim_hit & ~w_busy_rel);
   assign w_claim_on_busy = |(w_claim_hit &  w_busy_rel);
   assign w_release       = |(w_wr_hit & r_busy);
   assign w_cnt_op        = count_op(w_claim_new, w_release);

   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         r_busy           <= '0;
         r_busy_count     <= '0;
         r_claim_conflict <= 1'b0;
      end else begin
         // Claim is OR-ed in last, so it wins over a same-register release.
         r_busy <= w_busy_rel | w_claim_hit;
         if (w_claim_on_busy) begin
            r_claim_conflict <= 1'b1;
         end
         case (w_cnt_op)
            CNT_INC: r_busy_count <= r_busy_count + CNT_W'(1);
            CNT_DEC: r_busy_count <= r_busy_count - CNT_W'(1);
            default: r_busy_count <= r_busy_count;
         endcase
      end
   end

   assign o_busy           = r_busy;
   assign o_busy_count     = r_busy_count;
   assign o_claim_conflict = r_claim_conflict;

endmodule

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//
// Two-read / one-write register file with an integrated busy-bit
// scoreboard. Decode reads two operands and claims a destination each
// cycle; writeback writes a result and releases the claim.
//
// Ports:
//   i_clk                      rising-edge clock
//   i_clear                    synchronous active-high clear of all state
//   i_rd_a_sel, i_rd_b_sel     read selects
//   o_rd_a_data, o_rd_b_data   combinational read data, write-forwarded
//   o_rd_a_busy, o_rd_b_busy   combinational busy bits, write-forwarded
//   i_wr_en, i_wr_sel,
//   i_wr_data                  writeback strobe, register and data
//   i_claim_en, i_claim_sel    destination claim strobe and register
//   o_claim_conflict           sticky: a claim hit a still-busy register
//   o_busy_count               number of busy registers
//   o_testreg                  stored contents of register TEST_REG,
//                              never forwarded
//
// Strobes carry no handshake: each is a single-cycle request that is always
// accepted on the edge it is presented.
//
// A claim made this cycle does not show on o_rd_x_busy until the next
// cycle. Selects >= DEPTH read as zero / not busy.
// ---------------------------------------------------------------------------
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int SEL_W    = DEF_SEL_W,
   parameter int TEST_REG = DEF_TEST_REG
) (
   input  logic                       i_clk,
   input  logic                       i_clear,
   input  logic [SEL_W-1:0]           i_rd_a_sel,
   input  logic [SEL_W-1:0]           i_rd_b_sel,
   output logic [WIDTH-1:0]           o_rd_a_data,
   output logic [WIDTH-1:0]           o_rd_b_data,
   output logic                       o_rd_a_busy,
   output logic                       o_rd_b_busy,
   input  logic                       i_wr_en,
   input  logic [SEL_W-1:0]           i_wr_sel,
   input  logic [WIDTH-1:0]           i_wr_data,
   input  logic                       i_claim_en,
   input  logic [SEL_W-1:0]           i_claim_sel,
   output logic                       o_claim_conflict,
   output logic [$clog2(DEPTH+1)-1:0] o_busy_count,
   output logic [WIDTH-1:0]           o_testreg
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_regs [DEPTH];

   logic [DEPTH-1:0] w_wr_hit;
   logic [DEPTH-1:0] w_busy;
   logic [WIDTH-1:0] w_rd_a_data;
   logic [WIDTH-1:0] w_rd_b_data;
   logic             w_rd_a_busy;
   logic             w_rd_b_busy;

   reg_file_sb_scoreboard #(
      .DEPTH (DEPTH),
      .SEL_W (SEL_W),
      .CNT_W (CNT_W)
   ) u_scoreboard (
      .i_clk            (i_clk),
      .i_clear          (i_clear),
      .i_wr_en          (i_wr_en),
      .i_wr_sel         (i_wr_sel),
      .i_claim_en       (i_claim_en),
      .i_claim_sel      (i_claim_sel),
      .o_busy           (w_busy),
      .o_busy_count     (o_busy_count),
      .o_claim_conflict (o_claim_conflict)
   );

   // Write decode; an out-of-range select hits nothing.
   always_comb begin
      w_wr_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_wr_hit[i] = i_wr_en && (i_wr_sel == SEL_W'(i));
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_hit[i]) begin
               r_regs[i] <= i_wr_data;
            end
         end
      end
   end

   // Read muxes. A write to the selected register in the same cycle is
   // forwarded: its data is returned and the register reads as released.
   // No match (select >= DEPTH) leaves the zero defaults.
   always_comb begin
      w_rd_a_data = '0;
      w_rd_b_data = '0;
      w_rd_a_busy = 1'b0;
      w_rd_b_busy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_rd_a_sel == SEL_W'(i)) begin
            if (w_wr_hit[i]) begin
               w_rd_a_data = i_wr_data;
               w_rd_a_busy = 1'b0;
            end else begin
               w_rd_a_data = r_regs[i];
               w_rd_a_busy = w_busy[i];
            end
         end
         if (i_rd_b_sel == SEL_W'(i)) begin
            if (w_wr_hit[i]) begin
               w_rd_b_data = i_wr_data;
               w_rd_b_busy = 1'b0;
            end else begin
               w_rd_b_data = r_regs[i];
               w_rd_b_busy = w_busy[i];
            end
         end
      end
   end

   assign o_rd_a_data = w_rd_a_data;
   assign o_rd_b_data = w_rd_b_data;
   assign o_rd_a_busy = w_rd_a_busy;
   assign o_rd_b_busy = w_rd_b_busy;

   // Debug tap straight from storage, deliberately bypassing forwarding.
   assign o_testreg = r_regs[TEST_REG];

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
//
// Directed steps followed by a randomized phase. Expected values come from
// a behavioural model of the register file: an array of words, an array of
// busy flags and a conflict flag, updated once per edge from the rules of
// the block (write releases, claim sets, clear zeroes everything).
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

   localparam int WIDTH = 16;
   localparam int DEPTH = 64;
   localparam int SEL_W = 6;
   localparam int CNT_W = 7;

   logic             clk;
   logic             clear;
   logic [SEL_W-1:0] rd_a_sel;
   logic [SEL_W-1:0] rd_b_sel;
   logic [WIDTH-1:0] rd_a_data;
   logic [WIDTH-1:0] rd_b_data;
   logic             rd_a_busy;
   logic             rd_b_busy;
   logic             wr_en;
   logic [SEL_W-1:0] wr_sel;
   logic [WIDTH-1:0] wr_data;
   logic             claim_en;
   logic [SEL_W-1:0] claim_sel;
   logic             claim_conflict;
   logic [CNT_W-1:0] busy_count;
   logic [WIDTH-1:0] testreg;

   int n_checks;
   int n_fail;

   // Reference model state.
   logic [WIDTH-1:0] m_regs [DEPTH];
   bit               m_busy [DEPTH];
   bit               m_conflict;

   reg_file_sb #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .SEL_W    (SEL_W),
      .TEST_REG (0)
   ) dut (
      .i_clk            (clk),
      .i_clear          (clear),
      .i_rd_a_sel       (rd_a_sel),
      .i_rd_b_sel       (rd_b_sel),
      .o_rd_a_data      (rd_a_data),
      .o_rd_b_data      (rd_b_data),
      .o_rd_a_busy      (rd_a_busy),
      .o_rd_b_busy      (rd_b_busy),
      .i_wr_en          (wr_en),
      .i_wr_sel         (wr_sel),
      .i_wr_data        (wr_data),
      .i_claim_en       (claim_en),
      .i_claim_sel      (claim_sel),
      .o_claim_conflict (claim_conflict),
      .o_busy_count     (busy_count),
      .o_testreg        (testreg)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- model ----------------
   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < DEPTH; i++) c += m_busy[i] ? 1 : 0;
      return c;
   endfunction

   function automatic logic [WIDTH-1:0] m_read_data(input int sel);
      if (sel >= DEPTH) return '0;
      if (wr_en && int'(wr_sel) == sel) return wr_data;
      return m_regs[sel];
   endfunction

   function automatic logic m_read_busy(input int sel);
      if (sel >= DEPTH) return 1'b0;
      if (wr_en && int'(wr_sel) == sel) return 1'b0;
      return m_busy[sel];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_conflict = 1'b0;
   endtask

   // Applies the currently driven inputs as one clock edge.
   task automatic m_edge();
      if (clear) begin
         m_reset();
      end else begin
         if (wr_en && int'(wr_sel) < DEPTH) begin
            m_regs[wr_sel] = wr_data;
            m_busy[wr_sel] = 1'b0;
         end
         if (claim_en && int'(claim_sel) < DEPTH) begin
            if (m_busy[claim_sel]) m_conflict = 1'b1;
            m_busy[claim_sel] = 1'b1;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check("rd_a_data", 32'(rd_a_data), 32'(m_read_data(int'(rd_a_sel))));
      check("rd_b_data", 32'(rd_b_data), 32'(m_read_data(int'(rd_b_sel))));
      check("rd_a_busy", 32'(rd_a_busy), 32'(m_read_busy(int'(rd_a_sel))));
      check("rd_b_busy", 32'(rd_b_busy), 32'(m_read_busy(int'(rd_b_sel))));
      check("claim_conflict", 32'(claim_conflict), 32'(m_conflict));
      check("busy_count", 32'(busy_count), 32'(m_count()));
      check("testreg", 32'(testreg), 32'(m_regs[0]));
   endtask

   // ---------------- driver ----------------
   // Inputs change 1 time unit after the rising edge; outputs are sampled
   // on the falling edge.
   task automatic drive(input logic clr, input logic we, input int ws, input int wd,
                        input logic ce, input int cs, input int ra, input int rb);
      clear     = clr;
      wr_en     = we;
      wr_sel    = SEL_W'(ws);
      wr_data   = WIDTH'(wd);
      claim_en  = ce;
      claim_sel = SEL_W'(cs);
      rd_a_sel  = SEL_W'(ra);
      rd_b_sel  = SEL_W'(rb);
      #4;
   endtask

   task automatic tick();
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic step(input logic clr, input logic we, input int ws, input int wd,
                       input logic ce, input int cs, input int ra, input int rb);
      drive(clr, we, ws, wd, ce, cs, ra, rb);
      check_outputs();
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_reset();

      // Reset for one edge.
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0);
      tick();

      // Reset state.
      drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 1, 2);
      check_outputs();
      check("rst_rd_a_data", 32'(rd_a_data), 32'h0);
      check("rst_rd_b_data", 32'(rd_b_data), 32'h0);
      check("rst_busy_count", 32'(busy_count), 32'h0);
      check("rst_testreg", 32'(testreg), 32'h0);
      check("rst_conflict", 32'(claim_conflict), 32'h0);
      tick();

      // Write reg 0, debug tap shows it the next cycle.
      step(1'b0, 1'b1, 0, 'h000f, 1'b0, 0, 0, 1);
      drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1);
      check_outputs();
      check("testreg_after_wr", 32'(testreg), 32'h000f);
      check("rd_a_stored_r0", 32'(rd_a_data), 32'h000f);
      tick();

      // Dual read with forwarding on port b.
      step(1'b0, 1'b1, 3, 'h1234, 1'b0, 0, 0, 0);
      step(1'b0, 1'b1, 5, 'hbeef, 1'b0, 0, 0, 0);
      drive(1'b0, 1'b1, 5, 'h5555, 1'b0, 0, 3, 5);
      check_outputs();
      check("fwd_rd_a", 32'(rd_a_data), 32'h1234);
      check("fwd_rd_b", 32'(rd_b_data), 32'h5555);
      tick();

      // Claim / release of reg 7.
      step(1'b0, 1'b0, 0, 0, 1'b1, 7, 7, 0);
      drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 7, 5);
      check_outputs();
      check("claim7_busy", 32'(rd_a_busy), 32'h1);
      check("claim7_count", 32'(busy_count), 32'h1);
      tick();
      drive(1'b0, 1'b1, 7, 'h00aa, 1'b0, 0, 7, 7);
      check_outputs();
      check("rel7_fwd_busy", 32'(rd_a_busy), 32'h0);
      check("rel7_fwd_data", 32'(rd_b_data), 32'h00aa);
      tick();
      drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 7, 0);
      check_outputs();
      check("rel7_count", 32'(busy_count), 32'h0);
      check("rel7_stored", 32'(rd_a_data), 32'h00aa);
      tick();

      // Claim + write on already-busy reg 9.
      step(1'b0, 1'b0, 0, 0, 1'b1, 9, 9, 0);
      step(1'b0, 1'b1, 9, 'h0909, 1'b1, 9, 9, 0);
      drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 9, 0);
      check_outputs();
      check("cw9_busy", 32'(rd_a_busy), 32'h1);
      check("cw9_data", 32'(rd_a_data), 32'h0909);
      check("cw9_count", 32'(busy_count), 32'h1);
      check("cw9_conflict", 32'(claim_conflict), 32'h0);
      tick();
      step(1'b0, 1'b0, 0, 0, 1'b1, 9, 9, 0);
      drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 9, 0);
      check_outputs();
      check("conflict_set", 32'(claim_conflict), 32'h1);
      tick();
      drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 9, 0);
      check_outputs();
      check("conflict_hold", 32'(claim_conflict), 32'h1);
      tick();

      // Saturation: claim every register.
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b0, 0, 0, 1'b1, i, i, (i + 1) % DEPTH);
      end
      drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 63);
      check_outputs();
      check("sat_count", 32'(busy_count), 32'd64);
      check("sat_busy63", 32'(rd_b_busy), 32'h1);
      tick();

      // Clear together with claim and write: the operations are discarded.
      step(1'b1, 1'b1, 3, 'hffff, 1'b1, 3, 3, 5);
      for (int i = 0; i < DEPTH / 2; i++) begin
         drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 2 * i, 2 * i + 1);
         check_outputs();
         check("clr_rd_a", 32'(rd_a_data), 32'h0);
         check("clr_rd_b", 32'(rd_b_data), 32'h0);
         check("clr_busy_a", 32'(rd_a_busy), 32'h0);
         tick();
      end
      drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
      check("clr_count", 32'(busy_count), 32'h0);
      check("clr_conflict", 32'(claim_conflict), 32'h0);
      tick();

      // Randomized phase; selects are often drawn from a small range so
      // claims, writes and reads collide frequently.
      for (int n = 0; n < 600; n++) begin
         int ws, cs, ra, rb;
         ws = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
         cs = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
         ra = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
         rb = ($urandom_range(0, 3) == 0) ? ws : int'($urandom_range(0, 7));
         step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)), ws, int'($urandom_range(0, 65535)),
              1'($urandom_range(0, 1)), cs, ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
